// File: rtl/gbus_row_arb_pkg.sv
// Shared definitions for the head-row gbus arbiter.
//   VNUM / GBUS_ADDR / GBUS_DATA : default row geometry (cores per row, bus widths)
//   req_id_e                     : requester identity, also the tracker payload
//   arb_state_e                  : arbitration FSM states
package gbus_row_arb_pkg;

  localparam int VNUM      = 8;
  localparam int GBUS_ADDR = 12;
  localparam int GBUS_DATA = 64;

  typedef enum logic {
    REQ_CHIP = 1'b0,  // chip interface
    REQ_VEC  = 1'b1   // vector engine
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } arb_state_e;

  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_CHIP) ? REQ_VEC : REQ_CHIP;
  endfunction

endpackage

// File: rtl/gbus_row_arb_trk_fifo.sv
// gbus_trk_fifo: in-order tracker of outstanding read requester IDs.
//   clk, rst          : clock, synchronous active-high reset (empties the FIFO)
//   i_push / i_data   : enqueue one entry
//   i_pop             : dequeue the head (ignored while empty)
//   o_data            : current head entry (show-ahead)
//   o_full / o_empty  : level flags
// A push while full is taken when a pop happens in the same cycle.
module gbus_trk_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CNTW-1:0]  r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNTW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gbus_row_arb.sv
// gbus_row_arb: arbitrates two requesters (chip interface, vector engine)
// onto one head-row gbus and routes read responses back in order.
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/ready/we/lock      : per-requester handshake and command
//   req_core/addr/wdata          : per-requester packed target and payload
//   rsp_valid, rsp_data          : read response, one-hot to the requester
//   gbus_addr/wen/ren/wdata      : registered row bus (1-cycle latency)
//   gbus_rdata, gbus_rvalid      : row read return
//   err_orphan                   : sticky, read data with nothing outstanding
module gbus_row_arb
  import gbus_row_arb_pkg::*;
#(
  parameter int VNUM      = gbus_row_arb_pkg::VNUM,
  parameter int GBUS_ADDR = gbus_row_arb_pkg::GBUS_ADDR,
  parameter int GBUS_DATA = gbus_row_arb_pkg::GBUS_DATA,
  parameter int TRK_DEPTH = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   req_valid,
  output logic [1:0]                   req_ready,
  input  logic [1:0]                   req_we,
  input  logic [1:0]                   req_lock,
  input  logic [2*$clog2(VNUM)-1:0]    req_core,
  input  logic [2*GBUS_ADDR-1:0]       req_addr,
  input  logic [2*GBUS_DATA-1:0]       req_wdata,
  output logic [1:0]                   rsp_valid,
  output logic [GBUS_DATA-1:0]         rsp_data,
  output logic [GBUS_ADDR-1:0]         gbus_addr,
  output logic [VNUM-1:0]              gbus_wen,
  output logic [VNUM-1:0]              gbus_ren,
  output logic [GBUS_DATA-1:0]         gbus_wdata,
  input  logic [GBUS_DATA-1:0]         gbus_rdata,
  input  logic [VNUM-1:0]              gbus_rvalid,
  output logic                         err_orphan
);

  localparam int CW = $clog2(VNUM);
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e             r_state, w_state_next;
  req_id_e                r_prio, w_prio_next;   // winner of the next conflict
  logic [BW-1:0]          r_burst, w_burst_next; // grants in this lock beyond the opening one
  logic                   w_locked, w_expire, w_any;
  req_id_e                w_owner, w_pri, w_gid;
  logic [1:0]             w_can, w_grant;
  logic [CW-1:0]          w_core;
  logic [VNUM-1:0]        w_core_hot;
  logic                   w_trk_full, w_trk_empty;
  logic [0:0]             w_trk_head;
  logic                   w_any_rvalid;

  logic [GBUS_ADDR-1:0]   r_gbus_addr;
  logic [GBUS_DATA-1:0]   r_gbus_wdata, r_rsp_data;
  logic [VNUM-1:0]        r_gbus_wen, r_gbus_ren;
  logic [1:0]             r_rsp_valid;
  logic                   r_err_orphan;

  assign w_locked     = (r_state != ST_IDLE);
  assign w_owner      = (r_state == ST_LOCK1) ? REQ_VEC : REQ_CHIP;
  assign w_any_rvalid = |gbus_rvalid;

  // Reads are refused while the tracker is full; writes never stall.
  assign w_can[0] = req_valid[0] && (req_we[0] || !w_trk_full);
  assign w_can[1] = req_valid[1] && (req_we[1] || !w_trk_full);

  always_comb begin
    w_state_next = r_state;
    w_prio_next  = r_prio;
    w_burst_next = r_burst;
    w_any        = 1'b0;
    w_gid        = REQ_CHIP;
    // A full-length burst yields as soon as the other side is waiting;
    // that cycle is arbitrated as if idle with the other side first.
    w_expire = w_locked && (r_burst >= BW'(MAX_BURST - 1)) && req_valid[other_req(w_owner)];
    w_pri    = w_expire ? other_req(w_owner) : r_prio;

    if (!w_locked || w_expire) begin
      w_prio_next  = w_pri;
      w_state_next = ST_IDLE;
      if (w_can[w_pri]) begin
        w_gid = w_pri;
        w_any = 1'b1;
      end else if (w_can[other_req(w_pri)]) begin
        w_gid = other_req(w_pri);
        w_any = 1'b1;
      end
      if (w_any) begin
        w_prio_next = other_req(w_gid);
        if (req_lock[w_gid]) w_state_next = (w_gid == REQ_VEC) ? ST_LOCK1 : ST_LOCK0;
      end
    end else begin
      if (w_can[w_owner]) begin
        w_gid       = w_owner;
        w_any       = 1'b1;
        w_prio_next = other_req(w_owner);
        if (!req_lock[w_owner]) w_state_next = ST_IDLE;
      end else if (!req_valid[w_owner] && !req_lock[w_owner]) begin
        w_state_next = ST_IDLE;
      end
    end

    // Expiry that immediately re-locks the same owner still restarts the count.
    if ((w_state_next != r_state) || w_expire) begin
      w_burst_next = '0;
    end else if (w_locked && w_any && (r_burst < BW'(MAX_BURST - 1))) begin
      w_burst_next = r_burst + BW'(1);
    end
  end

  always_comb begin
    w_grant        = 2'b00;
    w_grant[w_gid] = w_any;
  end

  assign req_ready = rst ? 2'b00 : w_grant;

  assign w_core = req_core[int'(w_gid)*CW +: CW];

  // Out-of-range columns are still accepted but select no core.
  always_comb begin
    w_core_hot = '0;
    if (int'(w_core) < VNUM) w_core_hot[w_core] = 1'b1;
  end

  gbus_trk_fifo #(
    .DEPTH (TRK_DEPTH),
    .WIDTH (1)
  ) u_trk (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_any && !req_we[w_gid]),
    .i_data  (w_gid),
    .i_pop   (w_any_rvalid),
    .o_data  (w_trk_head),
    .o_full  (w_trk_full),
    .o_empty (w_trk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_prio  <= REQ_CHIP;
      r_burst <= '0;
    end else begin
      r_state <= w_state_next;
      r_prio  <= w_prio_next;
      r_burst <= w_burst_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gbus_addr  <= '0;
      r_gbus_wdata <= '0;
      r_gbus_wen   <= '0;
      r_gbus_ren   <= '0;
      r_rsp_data   <= '0;
      r_rsp_valid  <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_gbus_wen  <= '0;
      r_gbus_ren  <= '0;
      r_rsp_valid <= '0;
      if (w_any) begin
        r_gbus_addr  <= req_addr[int'(w_gid)*GBUS_ADDR +: GBUS_ADDR];
        r_gbus_wdata <= req_wdata[int'(w_gid)*GBUS_DATA +: GBUS_DATA];
        if (req_we[w_gid]) r_gbus_wen <= w_core_hot;
        else               r_gbus_ren <= w_core_hot;
      end
      if (w_any_rvalid) begin
        r_rsp_data <= gbus_rdata;
        if (w_trk_empty) r_err_orphan <= 1'b1;
        else             r_rsp_valid[w_trk_head] <= 1'b1;
      end
    end
  end

  assign gbus_addr  = r_gbus_addr;
  assign gbus_wdata = r_gbus_wdata;
  assign gbus_wen   = r_gbus_wen;
  assign gbus_ren   = r_gbus_ren;
  assign rsp_data   = r_rsp_data;
  assign rsp_valid  = r_rsp_valid;
  assign err_orphan = r_err_orphan;

endmodule
